// File: rtl/ber_sync_controller.sv
// ber_sync_controller
//   Sequences the PRBS receiver through acquisition, lock check and measurement.
//   Pulses get_word to reseed the receiver, turns its cumulative error/bit
//   snapshots into per-snapshot deltas, declares lock / loss-of-lock, keeps
//   48-bit saturating run totals and hands periodic reports to the UART
//   formatter over a valid/ready handshake.
//
//   Optional feature: define BER_CTRL_AUTO_RESYNC_EN to re-enter acquisition on
//   loss of lock (totals preserved). Without it, loss of lock only sets lol_flag_o.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start_i / stop_i           begin measurement (IDLE/FAIL only) / abort to IDLE
//   snap_valid_i               receiver snapshot strobe
//   snap_err_i, snap_total_i   receiver cumulative error / bit counts (32 bit)
//   get_word_o                 one-cycle reseed pulse to the receiver
//   locked_o, fail_o           state indicators
//   retry_cnt_o                failed acquisitions since start or last lock
//   lol_flag_o                 sticky loss-of-lock
//   acc_err_o, acc_total_o     48-bit saturating totals while locked
//   report_valid_o/ready_i     report handshake
//   report_err_o/total_o       held report payload
//   report_ovf_o               sticky: report due while previous still pending
module ber_sync_controller #(
    parameter int unsigned SETTLE_CYC    = 16,
    parameter int unsigned CHECK_SNAPS   = 4,
    parameter int unsigned LOCK_THRESH   = 0,
    parameter int unsigned LOCK_WIN      = 8,
    parameter int unsigned UNLOCK_THRESH = 100,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned REPORT_SNAPS  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        snap_valid_i,
    input  logic [31:0] snap_err_i,
    input  logic [31:0] snap_total_i,
    output logic        get_word_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [3:0]  retry_cnt_o,
    output logic        lol_flag_o,
    output logic [47:0] acc_err_o,
    output logic [47:0] acc_total_o,
    output logic        report_valid_o,
    input  logic        report_ready_i,
    output logic [47:0] report_err_o,
    output logic [47:0] report_total_o,
    output logic        report_ovf_o
);

    localparam int unsigned SNAP_W = 32;
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WIN_W  = 40;
    localparam int unsigned RTY_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACQ    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SNAP_W-1:0] prev_err_q, prev_err_d;
    logic [SNAP_W-1:0] prev_tot_q, prev_tot_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [WIN_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              lol_q, lol_d;
    logic [ACC_W-1:0]  acc_err_q, acc_err_d;
    logic [ACC_W-1:0]  acc_tot_q, acc_tot_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [ACC_W-1:0]  rpt_err_q, rpt_err_d;
    logic [ACC_W-1:0]  rpt_tot_q, rpt_tot_d;
    logic              ovf_q, ovf_d;

    // Event decode shared by next-state and datapath logic
    logic              snap_take;
    logic [SNAP_W-1:0] d_err;
    logic [SNAP_W-1:0] d_tot;
    logic [WIN_W-1:0]  win_err_sum;
    logic [CNT_W-1:0]  win_cnt_inc;
    logic [CNT_W-1:0]  rpt_cnt_inc;
    logic [RTY_W-1:0]  retry_inc;
    logic              settle_done;
    logic              baseline_ev;
    logic              chk_end;
    logic              chk_pass;
    logic              chk_give_up;
    logic              win_end;
    logic              lol_ev;
    logic              start_ev;
    logic [ACC_W-1:0]  acc_err_new;
    logic [ACC_W-1:0]  acc_tot_new;

    // Saturating 48 + 32 bit add
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [SNAP_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // stop overrides everything, including a coincident snapshot
    always_comb begin
        snap_take   = snap_valid_i && !stop_i;
        // Modular subtraction gives the right delta across receiver counter wrap
        d_err       = snap_err_i - prev_err_q;
        d_tot       = snap_total_i - prev_tot_q;
        win_err_sum = win_err_q + WIN_W'(d_err);
        win_cnt_inc = win_cnt_q + CNT_W'(1);
        rpt_cnt_inc = rpt_cnt_q + CNT_W'(1);
        retry_inc   = retry_q + RTY_W'(1);
        settle_done = (settle_cnt_q == CNT_W'(SETTLE_CYC));
        baseline_ev = (state_q == ST_SETTLE) && settle_done && snap_take;
        chk_end     = (state_q == ST_CHECK) && snap_take && (win_cnt_inc == CNT_W'(CHECK_SNAPS));
        chk_pass    = chk_end && (win_err_sum <= WIN_W'(LOCK_THRESH));
        chk_give_up = chk_end && !chk_pass && (retry_inc == RTY_W'(MAX_RETRY));
        win_end     = (state_q == ST_LOCKED) && snap_take && (win_cnt_inc == CNT_W'(LOCK_WIN));
        lol_ev      = win_end && (win_err_sum > WIN_W'(UNLOCK_THRESH));
        start_ev    = start_i && !stop_i && ((state_q == ST_IDLE) || (state_q == ST_FAIL));
        acc_err_new = sat_add(acc_err_q, d_err);
        acc_tot_new = sat_add(acc_tot_q, d_tot);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_FAIL: begin
                    if (start_i) state_d = ST_ACQ;
                end
                ST_ACQ: state_d = ST_SETTLE;
                ST_SETTLE: begin
                    if (baseline_ev) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (chk_pass)         state_d = ST_LOCKED;
                    else if (chk_give_up) state_d = ST_FAIL;
                    else if (chk_end)     state_d = ST_ACQ;
                end
                ST_LOCKED: begin
`ifdef BER_CTRL_AUTO_RESYNC_EN
                    if (lol_ev) state_d = ST_ACQ;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state register; get_word is gated off during reset
    always_comb begin
        get_word_o = (state_q == ST_ACQ) && !rst;
        locked_o   = (state_q == ST_LOCKED);
        fail_o     = (state_q == ST_FAIL);
    end

    // Datapath next-state
    always_comb begin
        prev_err_d   = prev_err_q;
        prev_tot_d   = prev_tot_q;
        settle_cnt_d = settle_cnt_q;
        win_err_d    = win_err_q;
        win_cnt_d    = win_cnt_q;
        rpt_cnt_d    = rpt_cnt_q;
        retry_d      = retry_q;
        lol_d        = lol_q;
        acc_err_d    = acc_err_q;
        acc_tot_d    = acc_tot_q;
        rpt_valid_d  = rpt_valid_q;
        rpt_err_d    = rpt_err_q;
        rpt_tot_d    = rpt_tot_q;
        ovf_d        = ovf_q;

        if (start_ev) begin
            acc_err_d = '0;
            acc_tot_d = '0;
            retry_d   = '0;
            lol_d     = 1'b0;
            ovf_d     = 1'b0;
        end

        // Accepted report drops next edge unless a fresh one loads below
        if (rpt_valid_q && report_ready_i) rpt_valid_d = 1'b0;

        // Settle timer runs only in SETTLE and stops once it reaches the target
        if (state_q != ST_SETTLE)  settle_cnt_d = '0;
        else if (!settle_done)     settle_cnt_d = settle_cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_SETTLE: begin
                if (baseline_ev) begin
                    prev_err_d = snap_err_i;
                    prev_tot_d = snap_total_i;
                    win_err_d  = '0;
                    win_cnt_d  = '0;
                end
            end
            ST_CHECK: begin
                if (snap_take) begin
                    prev_err_d = snap_err_i;
                    prev_tot_d = snap_total_i;
                    win_err_d  = win_err_sum;
                    win_cnt_d  = win_cnt_inc;
                    if (chk_end) begin
                        win_err_d = '0;
                        win_cnt_d = '0;
                        if (chk_pass) begin
                            retry_d   = '0;
                            rpt_cnt_d = '0;
                        end else begin
                            retry_d = retry_inc;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (snap_take) begin
                    prev_err_d = snap_err_i;
                    prev_tot_d = snap_total_i;
                    acc_err_d  = acc_err_new;
                    acc_tot_d  = acc_tot_new;
                    win_err_d  = win_err_sum;
                    win_cnt_d  = win_cnt_inc;
                    rpt_cnt_d  = rpt_cnt_inc;
                    if (win_end) begin
                        win_err_d = '0;
                        win_cnt_d = '0;
                    end
                    if (lol_ev) begin
                        lol_d = 1'b1;
`ifdef BER_CTRL_AUTO_RESYNC_EN
                        retry_d = '0;
`endif
                    end
                    // Report includes this snapshot's deltas; a pending one is never overwritten
                    if (rpt_cnt_inc == CNT_W'(REPORT_SNAPS)) begin
                        rpt_cnt_d = '0;
                        if (rpt_valid_q && !report_ready_i) begin
                            ovf_d = 1'b1;
                        end else begin
                            rpt_err_d   = acc_err_new;
                            rpt_tot_d   = acc_tot_new;
                            rpt_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (stop_i) rpt_valid_d = 1'b0;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_err_q   <= '0;
            prev_tot_q   <= '0;
            settle_cnt_q <= '0;
            win_err_q    <= '0;
            win_cnt_q    <= '0;
            rpt_cnt_q    <= '0;
            retry_q      <= '0;
            lol_q        <= 1'b0;
            acc_err_q    <= '0;
            acc_tot_q    <= '0;
            rpt_valid_q  <= 1'b0;
            rpt_err_q    <= '0;
            rpt_tot_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            prev_err_q   <= prev_err_d;
            prev_tot_q   <= prev_tot_d;
            settle_cnt_q <= settle_cnt_d;
            win_err_q    <= win_err_d;
            win_cnt_q    <= win_cnt_d;
            rpt_cnt_q    <= rpt_cnt_d;
            retry_q      <= retry_d;
            lol_q        <= lol_d;
            acc_err_q    <= acc_err_d;
            acc_tot_q    <= acc_tot_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_err_q    <= rpt_err_d;
            rpt_tot_q    <= rpt_tot_d;
            ovf_q        <= ovf_d;
        end
    end

    assign retry_cnt_o    = retry_q;
    assign lol_flag_o     = lol_q;
    assign acc_err_o      = acc_err_q;
    assign acc_total_o    = acc_tot_q;
    assign report_valid_o = rpt_valid_q;
    assign report_err_o   = rpt_err_q;
    assign report_total_o = rpt_tot_q;
    assign report_ovf_o   = ovf_q;

endmodule

// File: tb/tb_ber_sync_controller.sv
// Testbench for ber_sync_controller: directed snapshot sequences; accepted
// reports are checked by a monitor against an expected-report queue.
module tb_ber_sync_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, stop_i, snap_valid_i, report_ready_i;
    logic [31:0] snap_err_i, snap_total_i;
    logic        get_word_o, locked_o, fail_o, lol_flag_o, report_valid_o, report_ovf_o;
    logic [3:0]  retry_cnt_o;
    logic [47:0] acc_err_o, acc_total_o, report_err_o, report_total_o;

    ber_sync_controller #(
        .SETTLE_CYC(16), .CHECK_SNAPS(4), .LOCK_THRESH(0), .LOCK_WIN(8),
        .UNLOCK_THRESH(100), .MAX_RETRY(3), .REPORT_SNAPS(10)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .snap_valid_i(snap_valid_i), .snap_err_i(snap_err_i), .snap_total_i(snap_total_i),
        .get_word_o(get_word_o), .locked_o(locked_o), .fail_o(fail_o),
        .retry_cnt_o(retry_cnt_o), .lol_flag_o(lol_flag_o),
        .acc_err_o(acc_err_o), .acc_total_o(acc_total_o),
        .report_valid_o(report_valid_o), .report_ready_i(report_ready_i),
        .report_err_o(report_err_o), .report_total_o(report_total_o),
        .report_ovf_o(report_ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] err;
        logic [47:0] tot;
    } rpt_t;

    rpt_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          gw_cnt   = 0;
    logic        gw_prev  = 1'b0;
    logic [31:0] cur_err, cur_tot;
    int          gw0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(1); start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1; tick(1); stop_i = 1'b0;
    endtask

    task automatic accept_report();
        report_ready_i = 1'b1; tick(1); report_ready_i = 1'b0;
    endtask

    // Advance the modelled receiver counters and strobe one snapshot
    task automatic snap(input logic [31:0] de, input logic [31:0] dt);
        cur_err      = cur_err + de;
        cur_tot      = cur_tot + dt;
        snap_err_i   = cur_err;
        snap_total_i = cur_tot;
        snap_valid_i = 1'b1;
        tick(1);
        snap_valid_i = 1'b0;
    endtask

    // Monitor: get_word pulse width/count and report acceptance scoreboard
    always @(negedge clk) begin
        if (get_word_o) begin
            gw_cnt++;
            chk("get_word_single_cycle", 64'(gw_prev), 64'd0);
        end
        gw_prev = get_word_o;
        if (report_valid_o && report_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("report_unexpected", 64'd1, 64'd0);
            end else begin
                rpt_t e;
                e = exp_q.pop_front();
                chk("report_err", 64'(report_err_o), 64'(e.err));
                chk("report_total", 64'(report_total_o), 64'(e.tot));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; snap_valid_i = 1'b0;
        report_ready_i = 1'b0; snap_err_i = '0; snap_total_i = '0;
        cur_err = 32'd0; cur_tot = 32'd1000;
        @(negedge clk);
        chk("get_word_in_reset", 64'(get_word_o), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("reset_locked", 64'(locked_o), 64'd0);
        chk("reset_fail", 64'(fail_o), 64'd0);
        chk("reset_retry", 64'(retry_cnt_o), 64'd0);
        chk("reset_acc_total", 64'(acc_total_o), 64'd0);
        chk("reset_report_valid", 64'(report_valid_o), 64'd0);
        chk("reset_ovf_lol", 64'({report_ovf_o, lol_flag_o}), 64'd0);

        // Clean acquisition; an errored snapshot during settle must be ignored
        pulse_start();
        tick(5);
        snap(32'd1000, 32'd0);
        tick(25);
        snap(32'd0, 32'd0);                    // baseline
        repeat (3) snap(32'd0, 32'd101);
        chk("lock_not_before_4th", 64'(locked_o), 64'd0);
        snap(32'd0, 32'd101);
        chk("locked_after_4th", 64'(locked_o), 64'd1);
        chk("lock_retry_zero", 64'(retry_cnt_o), 64'd0);
        chk("lock_get_word_count", 64'(gw_cnt), 64'd1);

        // First report after 10 locked snapshots, held while not accepted
        exp_q.push_back('{err: 48'd10, tot: 48'd1010});
        repeat (10) snap(32'd1, 32'd101);
        chk("report_valid", 64'(report_valid_o), 64'd1);
        chk("report_total_held", 64'(report_total_o), 64'd1010);
        chk("report_err_held", 64'(report_err_o), 64'd10);
        pulse_start();                          // ignored while locked
        repeat (10) snap(32'd1, 32'd101);
        chk("report_ovf", 64'(report_ovf_o), 64'd1);
        chk("ovf_report_total_kept", 64'(report_total_o), 64'd1010);
        chk("acc_total_20", 64'(acc_total_o), 64'd2020);
        chk("acc_err_20", 64'(acc_err_o), 64'd20);
        chk("no_lol_yet", 64'(lol_flag_o), 64'd0);
        accept_report();
        chk("report_dropped", 64'(report_valid_o), 64'd0);
        chk("ovf_sticky", 64'(report_ovf_o), 64'd1);

        // Window total of exactly 100 errors is not loss of lock
        snap(32'd96, 32'd101);
        repeat (3) snap(32'd0, 32'd101);
        chk("lol_boundary_100", 64'(lol_flag_o), 64'd0);

        // Window with 101 errors; report due at snapshot 30
        exp_q.push_back('{err: 48'd217, tot: 48'd3030});
        snap(32'd101, 32'd101);
        repeat (7) snap(32'd0, 32'd101);
        chk("lol_flag", 64'(lol_flag_o), 64'd1);
        chk("acc_total_32", 64'(acc_total_o), 64'd3232);
`ifdef BER_CTRL_AUTO_RESYNC_EN
        tick(2);
        chk("resync_unlocked", 64'(locked_o), 64'd0);
        chk("resync_get_word", 64'(gw_cnt), 64'd2);
        chk("resync_retry", 64'(retry_cnt_o), 64'd0);
`else
        tick(2);
        chk("stay_locked", 64'(locked_o), 64'd1);
        chk("no_resync_get_word", 64'(gw_cnt), 64'd1);
`endif
        accept_report();

        // stop keeps totals; stop+start together stays idle
        pulse_stop();
        chk("stop_unlocked", 64'(locked_o), 64'd0);
        chk("stop_acc_kept", 64'(acc_total_o), 64'd3232);
        chk("stop_acc_err_kept", 64'(acc_err_o), 64'd217);
        gw0 = gw_cnt;
        start_i = 1'b1; stop_i = 1'b1; tick(1); start_i = 1'b0; stop_i = 1'b0;
        tick(3);
        chk("stop_wins_no_get_word", 64'(gw_cnt - gw0), 64'd0);
        chk("stop_wins_acc_kept", 64'(acc_total_o), 64'd3232);

        // Restart clears totals; receiver bit counter wraps in LOCKED
        pulse_start();
        tick(1);
        chk("start_clears_acc", 64'(acc_total_o), 64'd0);
        chk("start_clears_flags", 64'({lol_flag_o, report_ovf_o}), 64'd0);
        cur_err = 32'd7; cur_tot = 32'hFFFF_FE70;
        tick(25);
        snap(32'd0, 32'd0);
        repeat (4) snap(32'd0, 32'h60);
        chk("wrap_locked", 64'(locked_o), 64'd1);
        snap(32'd0, 32'h60);                   // 0xFFFF_FFF0 -> 0x0000_0050
        chk("wrap_delta_total", 64'(acc_total_o), 64'h60);
        chk("wrap_delta_err", 64'(acc_err_o), 64'd0);
        pulse_stop();
        chk("stop_wrap_acc_kept", 64'(acc_total_o), 64'h60);

        // stop in the middle of CHECK
        pulse_start();
        tick(25);
        snap(32'd0, 32'd0);
        repeat (2) snap(32'd0, 32'd96);
        pulse_stop();
        repeat (4) snap(32'd0, 32'd96);
        chk("stop_check_idle", 64'({locked_o, fail_o}), 64'd0);
        chk("stop_check_acc", 64'(acc_total_o), 64'd0);

        // Three errored acquisitions end in FAIL
        gw0 = gw_cnt;
        pulse_start();
        for (int a = 0; a < 3; a++) begin
            tick(25);
            snap(32'd0, 32'd0);
            repeat (4) snap(32'd5, 32'd101);
            if (a < 2) begin
                chk("retry_count", 64'(retry_cnt_o), 64'(a + 1));
                chk("retry_not_fail", 64'(fail_o), 64'd0);
            end
        end
        tick(5);
        chk("fail_set", 64'(fail_o), 64'd1);
        chk("fail_retry", 64'(retry_cnt_o), 64'd3);
        chk("fail_get_words", 64'(gw_cnt - gw0), 64'd3);
        chk("fail_not_locked", 64'(locked_o), 64'd0);

        // start from FAIL restarts acquisition; stop returns to IDLE
        pulse_start();
        tick(2);
        chk("restart_fail_clr", 64'(fail_o), 64'd0);
        chk("restart_retry_clr", 64'(retry_cnt_o), 64'd0);
        chk("restart_get_word", 64'(gw_cnt - gw0), 64'd4);
        pulse_stop();
        chk("final_idle", 64'({locked_o, fail_o}), 64'd0);

        tick(2);
        chk("report_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
